// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot mux/demux family: select legality check,
// holding-slot state encoding and default counter width.
package onehot_pkg;

    localparam int unsigned MAX_SEL_W         = 64;
    localparam int unsigned DEFAULT_CNT_WIDTH = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Exactly one bit set; callers zero-extend their select to MAX_SEL_W.
    function automatic logic is_onehot(input logic [MAX_SEL_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_SEL_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered holding slot: captures a beat on load, releases it on drain.
module demux_slot
    import onehot_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_state_e      state_q;
    slot_state_e      state_d;
    logic             drain_c;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A drain only counts while the slot actually holds a beat.
    always_comb begin
        state_d = state_q;
        drain_c = drain && (state_q == SLOT_FULL);
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (drain_c && !load) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // Data is held bit-stable unless a new beat is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    assign valid = (state_q == SLOT_FULL);
    assign data  = data_q;

endmodule

// File: rtl/onehot_demux.sv
// Routes one valid/ready stream to CHANNELS registered output slots by one-hot
// select; illegal selects are consumed, flagged and counted.
module onehot_demux
    import onehot_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [CHANNELS-1:0]       i_onehot,
    input  logic [WIDTH-1:0]          i_data,
    output logic [CHANNELS-1:0]       o_valid,
    input  logic [CHANNELS-1:0]       o_ready,
    output logic [CHANNELS*WIDTH-1:0] o_data,
    output logic                      err,
    input  logic                      err_clear,
    output logic [CNT_WIDTH-1:0]      drop_cnt
);

    logic                 sel_legal_c;
    logic                 sel_ready_c;
    logic                 ready_c;
    logic                 accept_c;
    logic                 drop_c;
    logic [CHANNELS-1:0]  load_c;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q;

    assign sel_legal_c = is_onehot(MAX_SEL_W'(i_onehot));

    // With a legal select only one term can be live, so the OR acts as a mux.
    always_comb begin
        sel_ready_c = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (i_onehot[k] && (!o_valid[k] || o_ready[k])) begin
                sel_ready_c = 1'b1;
            end
        end
    end

    // Illegal selects sink unconditionally so the upstream never deadlocks.
    assign ready_c  = sel_legal_c ? sel_ready_c : 1'b1;
    assign accept_c = i_valid && ready_c && sel_legal_c;
    assign drop_c   = i_valid && !sel_legal_c;
    assign load_c   = accept_c ? i_onehot : '0;
    assign i_ready  = ready_c;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load_c[k]),
            .load_data(i_data),
            .drain    (o_ready[k]),
            .valid    (o_valid[k]),
            .data     (o_data[k*WIDTH +: WIDTH])
        );
    end

    // Sticky error: a drop in the same cycle overrides a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (drop_c) begin
            err_q <= 1'b1;
        end else if (err_clear) begin
            err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_c && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign err      = err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_onehot_demux.sv
// Directed bench for onehot_demux: routing, backpressure, illegal selects,
// counter saturation (second instance with a 2-bit counter) and reset.
module tb_onehot_demux;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [CH-1:0] i_onehot;
    logic [W-1:0]  i_data;
    logic [CH-1:0] o_ready;
    logic          err_clear;

    logic            i_ready;
    logic [CH-1:0]   o_valid;
    logic [CH*W-1:0] o_data;
    logic            err;
    logic [7:0]      drop_cnt;

    logic            i_ready_s;
    logic [CH-1:0]   o_valid_s;
    logic [CH*W-1:0] o_data_s;
    logic            err_s;
    logic [1:0]      drop_cnt_s;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    onehot_demux #(.CHANNELS(CH), .WIDTH(W), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .i_onehot(i_onehot), .i_data(i_data), .o_valid(o_valid),
        .o_ready(o_ready), .o_data(o_data), .err(err),
        .err_clear(err_clear), .drop_cnt(drop_cnt)
    );

    onehot_demux #(.CHANNELS(CH), .WIDTH(W), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_s),
        .i_onehot(i_onehot), .i_data(i_data), .o_valid(o_valid_s),
        .o_ready(o_ready), .o_data(o_data_s), .err(err_s),
        .err_clear(err_clear), .drop_cnt(drop_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_onehot = 2'b01; i_data = '0;
        o_ready = '0; err_clear = 1'b0;
        tick(); tick();
        chk("rst_o_valid", 32'(o_valid), 32'h0);
        chk("rst_o_data", 32'(o_data), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_i_ready", 32'(i_ready), 32'h1);
        chk("rst_sat_o_valid", 32'(o_valid_s), 32'h0);
        chk("rst_sat_o_data", 32'(o_data_s), 32'h0);
        chk("rst_sat_err", 32'(err_s), 32'h0);
        chk("rst_sat_i_ready", 32'(i_ready_s), 32'h1);
        rst = 1'b0;

        // Basic route to channel 1, hold, then drain.
        i_valid = 1'b1; i_onehot = 2'b10; i_data = 8'hA5;
        tick();
        i_valid = 1'b0;
        chk("route_o_valid", 32'(o_valid), 32'h2);
        chk("route_o_data", 32'(o_data), 32'hA500);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_o_valid", 32'(o_valid), 32'h2);
            chk("hold_o_data", 32'(o_data), 32'hA500);
        end
        o_ready = 2'b10;
        tick();
        chk("drain_o_valid", 32'(o_valid), 32'h0);
        o_ready = 2'b00;

        // Backpressure then streaming on channel 0.
        i_valid = 1'b1; i_onehot = 2'b01; i_data = 8'h11;
        tick();
        chk("bp_fill", 32'(o_valid), 32'h1);
        i_data = 8'h01;
        #1 chk("bp_i_ready_low", 32'(i_ready), 32'h0);
        tick();
        chk("bp_held_data", 32'(o_data[7:0]), 32'h11);
        chk("bp_held_valid", 32'(o_valid), 32'h1);
        o_ready = 2'b01;
        #1 chk("bp_i_ready_high", 32'(i_ready), 32'h1);
        tick();
        chk("stream1_valid", 32'(o_valid), 32'h1);
        chk("stream1_data", 32'(o_data[7:0]), 32'h01);
        i_data = 8'h02;
        tick();
        chk("stream2_valid", 32'(o_valid), 32'h1);
        chk("stream2_data", 32'(o_data[7:0]), 32'h02);
        i_data = 8'h03;
        tick();
        chk("stream3_valid", 32'(o_valid), 32'h1);
        chk("stream3_data", 32'(o_data[7:0]), 32'h03);
        i_valid = 1'b0;
        tick();
        chk("stream_empty", 32'(o_valid), 32'h0);
        o_ready = 2'b00;

        // Channel 1 stalled full while channel 0 flows.
        i_valid = 1'b1; i_onehot = 2'b10; i_data = 8'h5C;
        tick();
        chk("ind_ch1_fill", 32'(o_valid), 32'h2);
        o_ready = 2'b01; i_onehot = 2'b01;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'(8'h21 + i);
            #1 chk("ind_i_ready", 32'(i_ready), 32'h1);
            tick();
            chk("ind_o_valid", 32'(o_valid), 32'h3);
            chk("ind_o_data", 32'(o_data), {16'h0, 8'h5C, 8'(8'h21 + i)});
        end
        i_valid = 1'b0;
        tick();
        chk("ind_ch0_drained", 32'(o_valid), 32'h2);
        chk("ind_ch1_stable", 32'(o_data[15:8]), 32'h5C);

        // Illegal selects are sunk and counted.
        i_valid = 1'b1; i_onehot = 2'b00; i_data = 8'hFF;
        #1 chk("ill00_i_ready", 32'(i_ready), 32'h1);
        tick();
        chk("ill00_o_valid", 32'(o_valid), 32'h2);
        chk("ill00_err", 32'(err), 32'h1);
        chk("ill00_drop_cnt", 32'(drop_cnt), 32'h1);
        i_onehot = 2'b11;
        #1 chk("ill11_i_ready", 32'(i_ready), 32'h1);
        tick();
        chk("ill11_o_valid", 32'(o_valid), 32'h2);
        chk("ill11_o_data", 32'(o_data), 32'h5C23);
        chk("ill11_err", 32'(err), 32'h1);
        chk("ill11_drop_cnt", 32'(drop_cnt), 32'h2);
        chk("ill11_sat_cnt", 32'(drop_cnt_s), 32'h2);
        i_onehot = 2'b00; err_clear = 1'b1;
        tick();
        chk("clr_drop_err", 32'(err), 32'h1);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'h3);
        i_valid = 1'b0;
        tick();
        chk("clr_err", 32'(err), 32'h0);
        chk("clr_cnt_kept", 32'(drop_cnt), 32'h3);
        chk("clr_sat_cnt", 32'(drop_cnt_s), 32'h3);
        err_clear = 1'b0;

        // Five more drops: 8-bit counter reaches 8, 2-bit counter stays at 3.
        i_valid = 1'b1; i_onehot = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        i_valid = 1'b0;
        chk("sat_cnt", 32'(drop_cnt_s), 32'h3);
        chk("sat_err", 32'(err_s), 32'h1);
        chk("wide_cnt", 32'(drop_cnt), 32'h8);

        // Reset with both slots full, and no load while reset is held.
        i_valid = 1'b1; i_onehot = 2'b01; i_data = 8'h77;
        tick();
        i_valid = 1'b0;
        chk("pre_rst_o_valid", 32'(o_valid), 32'h3);
        rst = 1'b1;
        tick();
        chk("mid_rst_o_valid", 32'(o_valid), 32'h0);
        chk("mid_rst_o_data", 32'(o_data), 32'h0);
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_sat_cnt", 32'(drop_cnt_s), 32'h0);
        i_valid = 1'b1; i_onehot = 2'b01; i_data = 8'h99;
        #1 chk("rst_hold_i_ready", 32'(i_ready), 32'h1);
        tick();
        chk("rst_no_load", 32'(o_valid), 32'h0);
        i_valid = 1'b0; rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(o_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
